// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Single-outstanding memory access sequencer. A start pulse in idle latches a
// computed address, store data and direction, then issues one memory request
// and waits for mem_ready (bounded by TIMEOUT cycles). Completion is signalled
// by a one-cycle done pulse with error qualifying it.
//
// Optional feature: define MEM_ACCESS_ALIGN_CHECK_EN to reject accesses whose
// computed address is odd (done+error without a memory request).
//
// Ports
//   clock, reset_n            : system clock (rising edge), async active-low reset
//   start, op_write           : begin access (idle only), 1 = store / 0 = load
//   addr_sel, data_sel        : address source and store-data source selects
//   pc, sp_in, imm            : address operands
//   mary_data, shelley_data,
//   ra_data                   : register operands (address and store data)
//   mem_req, mem_we,
//   mem_addr, mem_wdata       : memory request side
//   mem_ready, mem_rdata      : memory completion and load data
//   busy, done, error,
//   rd_data                   : status and last successful load result
module mem_access_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned IMM_W   = 7,
  parameter int unsigned SP_STEP = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op_write,
  input  logic [2:0]        addr_sel,
  input  logic [1:0]        data_sel,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] mary_data,
  input  logic [DATA_W-1:0] shelley_data,
  input  logic [DATA_W-1:0] ra_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // Address operand preparation; all sums wrap modulo 2^ADDR_W by width.
  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] calc_addr;
  logic              sel_legal;
  logic              addr_fault;
  logic [DATA_W-1:0] calc_wdata;

  assign imm_sext = ADDR_W'($signed(imm));

  always_comb begin
    calc_addr = '0;
    sel_legal = 1'b1;
    unique case (addr_sel)
      3'b000:  calc_addr = pc;
      3'b001:  calc_addr = imm_sext;
      3'b010:  calc_addr = mary_data[ADDR_W-1:0];
      3'b011:  calc_addr = shelley_data[ADDR_W-1:0];
      3'b100:  calc_addr = sp_in + ADDR_W'(SP_STEP);
      3'b101:  calc_addr = sp_in + (imm_sext << 2);
      default: sel_legal = 1'b0;
    endcase
  end

  always_comb begin
    calc_wdata = '0;
    unique case (data_sel)
      2'b00:   calc_wdata = mary_data;
      2'b01:   calc_wdata = shelley_data;
      2'b10:   calc_wdata = ra_data;
      default: calc_wdata = '0;
    endcase
  end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  // Odd addresses are rejected before any memory request is made.
  assign addr_fault = sel_legal & calc_addr[0];
`else
  assign addr_fault = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    mem_req_d = 1'b0;
    mem_we_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          we_d   = op_write;
          if (!sel_legal) begin
            // Illegal select: nothing to latch, complete with error.
            state_d = StDone;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            addr_d  = calc_addr;
            wdata_d = calc_wdata;
            if (addr_fault) begin
              state_d = StDone;
              done_d  = 1'b1;
              error_d = 1'b1;
            end else begin
              state_d   = StReq;
              cnt_d     = '0;
              mem_req_d = 1'b1;
              mem_we_d  = op_write;
            end
          end
        end
      end

      StReq: begin
        busy_d = 1'b1;
        if (mem_ready) begin
          // Ready wins over a coincident timeout.
          state_d = StDone;
          done_d  = 1'b1;
          if (!we_q) begin
            rd_data_d = mem_rdata;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          mem_req_d = 1'b1;
          mem_we_d  = we_q;
        end
      end

      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios followed by randomized
// accesses, all checked against a behavioural model of the access rules.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, op_write;
  logic [2:0]  addr_sel;
  logic [1:0]  data_sel;
  logic [15:0] pc, sp_in;
  logic [6:0]  imm;
  logic [15:0] mary_data, shelley_data, ra_data;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        busy, done, error;
  logic [15:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [15:0] exp_rd;
  logic [15:0] last_addr;
  logic [15:0] last_wdata;

  mem_access_unit #(
    .DATA_W (16),
    .ADDR_W (16),
    .IMM_W  (7),
    .SP_STEP(2),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op_write    (op_write),
    .addr_sel    (addr_sel),
    .data_sel    (data_sel),
    .pc          (pc),
    .sp_in       (sp_in),
    .imm         (imm),
    .mary_data   (mary_data),
    .shelley_data(shelley_data),
    .ra_data     (ra_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .rd_data     (rd_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Effective address from the selection rules, using integer arithmetic
  // reduced modulo 2^16.
  function automatic logic [15:0] model_addr(input int sel, input logic [15:0] pc_v,
                                             input logic [15:0] sp_v, input logic [6:0] imm_v,
                                             input logic [15:0] m_v, input logic [15:0] s_v);
    int simm;
    int a;
    simm = int'(imm_v);
    if (simm >= 64) simm = simm - 128;
    case (sel)
      0:       a = int'(pc_v);
      1:       a = simm;
      2:       a = int'(m_v);
      3:       a = int'(s_v);
      4:       a = int'(sp_v) + 2;
      5:       a = int'(sp_v) + simm * 4;
      default: a = 0;
    endcase
    return 16'(((a % 65536) + 65536) % 65536);
  endfunction

  function automatic logic [15:0] model_wdata(input int dsel, input logic [15:0] m_v,
                                              input logic [15:0] s_v, input logic [15:0] r_v);
    case (dsel)
      0:       return m_v;
      1:       return s_v;
      2:       return r_v;
      default: return 16'h0000;
    endcase
  endfunction

  // Random junk on every operand input; the DUT must ignore it outside idle.
  task automatic scramble();
    start        = 1'($urandom);
    op_write     = 1'($urandom);
    addr_sel     = 3'($urandom);
    data_sel     = 2'($urandom);
    pc           = 16'($urandom);
    sp_in        = 16'($urandom);
    imm          = 7'($urandom);
    mary_data    = 16'($urandom);
    shelley_data = 16'($urandom);
    ra_data      = 16'($urandom);
  endtask

  // Performs one access from idle. Called at a negedge; returns at a negedge
  // with the DUT back in idle. ready_at < 0 means mem_ready never arrives.
  task automatic run_access(input string tag, input int sel, input int dsel, input bit we,
                            input int ready_at, input logic [15:0] rdata,
                            input logic [15:0] pc_v, input logic [15:0] sp_v,
                            input logic [6:0] imm_v, input logic [15:0] m_v,
                            input logic [15:0] s_v, input logic [15:0] r_v);
    logic [15:0] ea, ew;
    bit          fault, err;
    int          exit_k;
    ea    = model_addr(sel, pc_v, sp_v, imm_v, m_v, s_v);
    ew    = model_wdata(dsel, m_v, s_v, r_v);
    fault = (sel >= 6);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (sel < 6 && ea[0]) fault = 1'b1;
`endif
    start = 1'b1; op_write = we; addr_sel = 3'(sel); data_sel = 2'(dsel);
    pc = pc_v; sp_in = sp_v; imm = imm_v;
    mary_data = m_v; shelley_data = s_v; ra_data = r_v;
    @(posedge clock); #1;
    scramble();
    @(negedge clock);
    if (fault) begin
      if (sel < 6) begin
        last_addr  = ea;
        last_wdata = ew;
      end
      check({tag, "_fault_done"}, 32'(done), 1);
      check({tag, "_fault_err"}, 32'(error), 1);
      check({tag, "_fault_noreq"}, 32'(mem_req), 0);
      check({tag, "_fault_busy"}, 32'(busy), 1);
      check({tag, "_fault_addr"}, 32'(mem_addr), 32'(last_addr));
    end else begin
      last_addr  = ea;
      last_wdata = ew;
      err    = (ready_at < 0) || (ready_at >= TIMEOUT);
      exit_k = err ? TIMEOUT - 1 : ready_at;
      for (int k = 0; k <= exit_k; k++) begin
        check({tag, "_req"}, 32'(mem_req), 1);
        check({tag, "_we"}, 32'(mem_we), 32'(we));
        check({tag, "_addr"}, 32'(mem_addr), 32'(ea));
        check({tag, "_wdata"}, 32'(mem_wdata), 32'(ew));
        check({tag, "_nodone"}, 32'(done), 0);
        mem_ready = (k == ready_at);
        mem_rdata = (k == ready_at) ? rdata : 16'($urandom);
        @(negedge clock);
        mem_ready = 1'b0;
        scramble();
      end
      if (!err && !we) exp_rd = rdata;
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_err"}, 32'(error), 32'(err));
      check({tag, "_req_low"}, 32'(mem_req), 0);
      check({tag, "_we_low"}, 32'(mem_we), 0);
      check({tag, "_busy"}, 32'(busy), 1);
      check({tag, "_rd"}, 32'(rd_data), 32'(exp_rd));
    end
    start = 1'b0;
    @(negedge clock);
    check({tag, "_idle_done"}, 32'(done), 0);
    check({tag, "_idle_busy"}, 32'(busy), 0);
    check({tag, "_idle_err"}, 32'(error), 0);
    check({tag, "_idle_addr"}, 32'(mem_addr), 32'(last_addr));
    check({tag, "_idle_wdata"}, 32'(mem_wdata), 32'(last_wdata));
    check({tag, "_idle_rd"}, 32'(rd_data), 32'(exp_rd));
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; op_write = 1'b0; addr_sel = '0; data_sel = '0;
    pc = '0; sp_in = '0; imm = '0; mary_data = '0; shelley_data = '0; ra_data = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    exp_rd = '0; last_addr = '0; last_wdata = '0;

    // Reset state
    #12;
    check("rst_req", 32'(mem_req), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(error), 0);
    check("rst_rd", 32'(rd_data), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Stack-slot load, ready on the fourth REQ cycle; start right after reset
    run_access("load_sp", 4, 0, 1'b0, 3, 16'hBEEF,
               16'h0000, 16'h0100, 7'h00, 16'h1111, 16'h2222, 16'h3333);
    check("load_sp_addr", 32'(last_addr), 32'h0102);
    // Store via sp + (imm<<2) with imm = -1
    run_access("store_imm", 5, 2, 1'b1, 0, 16'hDEAD,
               16'h0000, 16'h0010, 7'h7F, 16'h1111, 16'h2222, 16'h1234);
    // Timeout with mem_ready never asserted
    run_access("timeout", 0, 1, 1'b0, -1, 16'h5555,
               16'h0200, 16'h0000, 7'h00, 16'h0, 16'hA5A5, 16'h0);
    // Ready coincident with the final timeout cycle: ready wins
    run_access("ready_at_limit", 2, 0, 1'b0, TIMEOUT - 1, 16'h7E57,
               16'h0000, 16'h0000, 7'h00, 16'h0444, 16'h0, 16'h0);
    // Address wrap: 0xFFFF + 2
    run_access("wrap", 4, 3, 1'b0, 1, 16'hC0DE,
               16'h0000, 16'hFFFF, 7'h00, 16'h0, 16'h0, 16'h0);
    // Illegal select goes straight to done+error
    run_access("illegal", 7, 0, 1'b0, 0, 16'h0,
               16'h0000, 16'h0000, 7'h00, 16'h9999, 16'h0, 16'h0);

    // mem_ready while idle must be ignored
    mem_ready = 1'b1; mem_rdata = 16'hF00D;
    @(negedge clock);
    mem_ready = 1'b0;
    check("idle_ready_busy", 32'(busy), 0);
    check("idle_ready_done", 32'(done), 0);
    check("idle_ready_rd", 32'(rd_data), 32'(exp_rd));

    // Reset two cycles into REQ
    start = 1'b1; addr_sel = 3'd0; pc = 16'h0040; op_write = 1'b0; data_sel = 2'd0;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("mid_rst_req_pre", 32'(mem_req), 1);
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_addr", 32'(mem_addr), 0);
    check("mid_rst_rd", 32'(rd_data), 0);
    exp_rd = '0; last_addr = '0; last_wdata = '0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_done", 32'(done), 0);
    check("post_rst_busy", 32'(busy), 0);
    run_access("after_rst", 1, 1, 1'b0, 2, 16'h4321,
               16'h0000, 16'h0000, 7'h05, 16'h0, 16'h6666, 16'h0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      run_access("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 1'($urandom), int'($urandom_range(0, 17)), 16'($urandom),
                 16'($urandom), 16'($urandom), 7'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, 16, width of data paths and registers in bits.
REQ-002 Parameter ADDR_W, 16, width of memory address in bits.
REQ-003 Parameter IMM_W, 7, width of the immediate field.
REQ-004 Parameter SP_STEP, 2, stack-pointer increment for push-slot addressing.
REQ-005 Parameter TIMEOUT, 15, maximum cycles in REQ waiting for mem_ready (range 1..255).
REQ-006 Ports, in order: clock in 1, single system clock, rising edge; reset_n in 1, asynchronous active-low reset.
REQ-007 start in 1, begin access (sampled only in IDLE); op_write in 1, 1=store, 0=load.
REQ-008 addr_sel in 3, address source; data_sel in 2, store-data source.
REQ-009 pc, sp_in in ADDR_W, program counter and stack pointer; imm in IMM_W, immediate.
REQ-010 mary_data, shelley_data, ra_data in DATA_W, register operands.
REQ-011 mem_req out 1, memory request; mem_we out 1, write qualifier; mem_addr out ADDR_W; mem_wdata out DATA_W.
REQ-012 mem_ready in 1, memory completion; mem_rdata in DATA_W, load data valid with mem_ready.
REQ-013 busy out 1, access in progress; done out 1, one-cycle completion pulse; error out 1, valid with done; rd_data out DATA_W, last load result.

Function
REQ-014 FSM states IDLE, REQ, DONE; busy SHALL be 1 in REQ and DONE, 0 in IDLE.
REQ-015 IDLE with start=1 SHALL latch address, store data and op_write into internal registers and go to REQ next cycle; start in REQ/DONE SHALL be ignored.
REQ-016 addr_sel: 000 pc; 001 sign-extended imm; 010 mary_data[ADDR_W-1:0]; 011 shelley_data[ADDR_W-1:0]; 100 sp_in+SP_STEP; 101 sp_in+(sign-extended imm<<2).
REQ-017 All address arithmetic SHALL be modulo 2^ADDR_W (wrap silently, e.g. 16'hFFFF+2 = 16'h0001).
REQ-018 data_sel: 00 mary_data, 01 shelley_data, 10 ra_data, 11 all-zero.
REQ-019 addr_sel 110/111 at start SHALL skip REQ, go directly to DONE with error=1, no mem_req.
REQ-020 In REQ mem_req=1, mem_we=latched op_write, mem_addr/mem_wdata SHALL hold latched values constant until exit.
REQ-021 Outside REQ mem_req=0, mem_we=0; mem_addr/mem_wdata hold last latched values.
REQ-022 REQ with mem_ready=1 SHALL go to DONE; on load rd_data SHALL capture mem_rdata on that edge.
REQ-023 A wait counter SHALL clear on REQ entry and increment each REQ cycle without mem_ready; reaching TIMEOUT SHALL go to DONE with error=1, rd_data unchanged.
REQ-024 mem_ready and timeout in the same cycle: mem_ready wins, error=0.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; minimum start-to-done latency 2 cycles (start edge, ready in first REQ cycle).
REQ-026 rd_data SHALL change only on successful loads; stores SHALL not modify it.
REQ-027 mem_ready outside REQ SHALL be ignored.

Reset
REQ-028 reset_n=0 SHALL asynchronously force IDLE, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, rd_data=0.
REQ-029 Reset during REQ SHALL drop mem_req immediately, discard the access, produce no done pulse.
REQ-030 First start honoured on the first rising edge after reset_n deasserts.

Configuration
REQ-031 Macro MEM_ACCESS_ALIGN_CHECK_EN defined: computed address with bit 0 = 1 SHALL go directly to DONE with error=1, no mem_req.
REQ-032 Macro undefined: no alignment check; odd addresses proceed to REQ normally.

Verification
REQ-033 Load: addr_sel=100, sp_in=16'h0100, mem_ready after 3 REQ cycles, mem_rdata=16'hBEEF -> mem_addr=16'h0102, mem_we=0, done with error=0, rd_data=16'hBEEF.
REQ-034 Store: addr_sel=101, sp_in=16'h0010, imm=7'h7F (-1), data_sel=10, ra_data=16'h1234 -> mem_addr=16'h000C, mem_we=1, mem_wdata=16'h1234, rd_data unchanged.
REQ-035 Timeout: TIMEOUT=15, mem_ready held 0 -> done with error=1 exactly 15 REQ cycles after REQ entry, mem_req low after.
REQ-036 Wrap/illegal: sp_in=16'hFFFF, addr_sel=100 -> mem_addr=16'h0001 (error=1, no mem_req if MEM_ACCESS_ALIGN_CHECK_EN defined); addr_sel=111 -> done+error next cycle, no mem_req.
REQ-037 Reset mid-access: reset_n low 2 cycles into REQ -> mem_req, busy 0 immediately, no done; subsequent start completes normally.
